gb_timer_ctrl: RTL
==================

// Module: gb_timer_ctrl
// PURPOSE
//  Game Boy DIV/TIMA/TMA/TAC timer engine sitting directly downstream of the io_bus_parser_reg
//  instances at FF04-FF07. Consumes their O_DATA_READ values, snoops CPU bus writes, and
//  produces register write-backs (I_DATA_WR/I_REG_WR_EN side) plus the timer interrupt request.
//  Register storage stays in the parsers; this block owns only counting and sequencing.
// PARAMETERS
//  P_DIV_ADDR   16'hFF04  DIV register address (CPU write here clears the divider)
//  P_TIMA_ADDR  16'hFF05  TIMA register address (CPU write cancels pending overflow reload)
// PORTS
//  I_CLK          in   1   system clock
//  I_ASYNC_RESET  in   1   asynchronous reset, active high
//  I_CLK_EN       in   1   4.194304 MHz tick enable; all counting advances only when high
//  I_ADDR_BUS     in   16  CPU address bus (snoop)
//  I_WE_BUS       in   1   CPU bus write strobe (snoop)
//  I_WAIT         in   1   O_WAIT from parsers; high = bus write in progress, defer write-backs
//  I_TIMA         in   8   current TIMA from FF05 parser
//  I_TMA          in   8   current TMA from FF06 parser
//  I_TAC          in   8   current TAC from FF07 parser (bit2 enable, bits1:0 rate)
//  O_DIV_DATA     out  8   new DIV value for FF04 parser
//  O_DIV_WR_EN    out  1   one-cycle write strobe to FF04 parser
//  O_TIMA_DATA    out  8   new TIMA value for FF05 parser
//  O_TIMA_WR_EN   out  1   one-cycle write strobe to FF05 parser
//  O_INT_REQ      out  1   one-cycle timer interrupt pulse to IF bit 2
// BEHAVIOUR
//  - Reset (async, any time): div_cnt=16'h0000, tima_shadow=8'h00, FSM=IDLE, all pending flags
//    clear, all outputs 0. Reset mid-overflow discards reload and interrupt.
//  - div_cnt: 16-bit, +1 per I_CLK_EN, wraps FFFF->0000. DIV = div_cnt[15:8].
//  - DIV write-back: when div_cnt[15:8] changes, set div_pend with value; CPU write to P_DIV_ADDR
//    (I_WE_BUS & addr match) clears div_cnt to 0 next cycle and sets div_pend with 8'h00
//    (overrides any pending value). Clear also drops input to edge detector (see below).
//  - Write-back rule (DIV and TIMA independently): strobe O_*_WR_EN for exactly one cycle, only
//    in a cycle with I_WAIT=0; while I_WAIT=1 pending value is held, newest value wins.
//    O_*_DATA is valid in the strobe cycle; parser register updates one cycle after strobe.
//  - Rate select bit: TAC[1:0] 00->div_cnt[9], 01->[3], 10->[5], 11->[7].
//    tick_in = TAC[2] & selected bit; registered copy tick_d; increment on tick_d & ~tick_in
//    (falling edge; disabling TAC or DIV clear while bit high also increments, as on hardware).
//  - tima_shadow: loaded from I_TIMA each cycle when no TIMA write pending/in flight (covers
//    2 cycles after own strobe and CPU writes); increments/reloads operate on tima_shadow.
//  - FSM: IDLE -> on increment: if shadow!=FF, pend shadow+1, stay IDLE; if shadow==FF, pend 8'h00
//    -> OVF_WAIT. OVF_WAIT: hold 4 I_CLK_EN ticks (one M-cycle, TIMA reads 00) -> RELOAD.
//    RELOAD: pend I_TMA (sampled this cycle), pulse O_INT_REQ for 1 I_CLK cycle -> IDLE.
//  - CPU write to P_TIMA_ADDR during OVF_WAIT: abort to IDLE, no reload, no interrupt; pending
//    TIMA write-back discarded (CPU value wins). In RELOAD cycle CPU write is ignored in favour of TMA.
//  - Increment arriving in OVF_WAIT/RELOAD: ignored (cannot occur at legal rates; not queued).
//  - All 8-bit arithmetic wraps modulo 256; no carry beyond overflow detection.
// TESTING
//  1. Reset, 256 I_CLK_EN ticks -> one O_DIV_WR_EN with O_DIV_DATA=01; none earlier.
//  2. TAC=05, TIMA=00, 64 ticks -> four O_TIMA_WR_EN strobes, final data 04.
//  3. TAC=05, TMA=AB, TIMA=FF, 16 ticks -> write 00, 4 ticks later write AB + single O_INT_REQ.
//  4. Overflow then CPU write FF05=33 within OVF_WAIT -> no AB write, no O_INT_REQ.
//  5. div_cnt=0x02F0, CPU write FF04 -> next cycle div_cnt=0, O_DIV_DATA=00 strobe; TAC=06 edge increments TIMA once.
//  6. Hold I_WAIT=1 across a pending TIMA increment -> no strobe until I_WAIT=0, then one strobe.
//     Assert I_ASYNC_RESET mid-OVF_WAIT -> all outputs 0 immediately, no interrupt after release.

Source files
------------

// File: rtl/gb_timer_ctrl.sv
// Game Boy DIV/TIMA timer engine: counts the divider, detects TIMA ticks,
// sequences overflow/reload and issues one-cycle write-backs to the FF04/FF05 parsers.
module gb_timer_ctrl #(
  parameter logic [15:0] P_DIV_ADDR  = 16'hFF04,
  parameter logic [15:0] P_TIMA_ADDR = 16'hFF05
) (
  input  logic        I_CLK,
  input  logic        I_ASYNC_RESET,
  input  logic        I_CLK_EN,
  input  logic [15:0] I_ADDR_BUS,
  input  logic        I_WE_BUS,
  input  logic        I_WAIT,
  input  logic [7:0]  I_TIMA,
  input  logic [7:0]  I_TMA,
  input  logic [7:0]  I_TAC,
  output logic [7:0]  O_DIV_DATA,
  output logic        O_DIV_WR_EN,
  output logic [7:0]  O_TIMA_DATA,
  output logic        O_TIMA_WR_EN,
  output logic        O_INT_REQ
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OVF_WAIT,
    ST_RELOAD
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] div_cnt_q, div_cnt_d;
  logic        div_pend_q, div_pend_d;
  logic [7:0]  div_val_q, div_val_d;
  logic        tima_pend_q, tima_pend_d;
  logic [7:0]  tima_val_q, tima_val_d;
  logic [7:0]  tima_shadow_q, tima_shadow_d;
  logic [1:0]  tima_hold_q, tima_hold_d;
  logic [1:0]  ovf_cnt_q, ovf_cnt_d;
  logic        tick_q, tick_d;

  logic        cpu_div_wr;
  logic        cpu_tima_wr;
  logic        div_wr_en;
  logic        tima_wr_en;
  logic        sel_bit;
  logic        tick_in;
  logic        tima_inc;
  logic [7:0]  shadow_cur;
  logic        unused_tac;

  assign unused_tac = ^I_TAC[7:3];

  always_comb begin
    cpu_div_wr  = I_WE_BUS & (I_ADDR_BUS == P_DIV_ADDR);
    cpu_tima_wr = I_WE_BUS & (I_ADDR_BUS == P_TIMA_ADDR);
    div_wr_en   = div_pend_q & ~I_WAIT;
    tima_wr_en  = tima_pend_q & ~I_WAIT;

    div_cnt_d = div_cnt_q;
    if (cpu_div_wr) begin
      div_cnt_d = 16'h0000;
    end else if (I_CLK_EN) begin
      div_cnt_d = div_cnt_q + 16'd1;
    end

    // A CPU clear always re-announces DIV=00, even if the upper byte was already zero.
    div_pend_d = div_pend_q & ~div_wr_en;
    div_val_d  = div_val_q;
    if (cpu_div_wr || (div_cnt_d[15:8] != div_cnt_q[15:8])) begin
      div_pend_d = 1'b1;
      div_val_d  = div_cnt_d[15:8];
    end

    case (I_TAC[1:0])
      2'b00:   sel_bit = div_cnt_q[9];
      2'b01:   sel_bit = div_cnt_q[3];
      2'b10:   sel_bit = div_cnt_q[5];
      default: sel_bit = div_cnt_q[7];
    endcase
    tick_in  = I_TAC[2] & sel_bit;
    tick_d   = tick_in;
    tima_inc = tick_q & ~tick_in;
  end

  always_comb begin
    tima_pend_d   = tima_pend_q & ~tima_wr_en;
    tima_val_d    = tima_val_q;
    tima_shadow_d = tima_shadow_q;
    state_d       = state_q;
    ovf_cnt_d     = ovf_cnt_q;

    tima_hold_d = tima_hold_q;
    if (tima_wr_en || cpu_tima_wr) begin
      tima_hold_d = 2'd2;
    end else if (tima_hold_q != 2'd0) begin
      tima_hold_d = tima_hold_q - 2'd1;
    end

    // Track the parser only while no write of ours or the CPU's can still be landing.
    shadow_cur = tima_shadow_q;
    if (!tima_pend_q && (tima_hold_q == 2'd0) && !cpu_tima_wr) begin
      shadow_cur = I_TIMA;
    end
    tima_shadow_d = shadow_cur;

    case (state_q)
      ST_IDLE: begin
        if (tima_inc) begin
          tima_pend_d = 1'b1;
          if (shadow_cur == 8'hFF) begin
            tima_val_d    = 8'h00;
            tima_shadow_d = 8'h00;
            ovf_cnt_d     = 2'd0;
            state_d       = ST_OVF_WAIT;
          end else begin
            tima_val_d    = shadow_cur + 8'd1;
            tima_shadow_d = shadow_cur + 8'd1;
          end
        end
      end
      ST_OVF_WAIT: begin
        if (cpu_tima_wr) begin
          tima_pend_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (I_CLK_EN) begin
          if (ovf_cnt_q == 2'd3) begin
            state_d = ST_RELOAD;
          end else begin
            ovf_cnt_d = ovf_cnt_q + 2'd1;
          end
        end
      end
      ST_RELOAD: begin
        tima_pend_d   = 1'b1;
        tima_val_d    = I_TMA;
        tima_shadow_d = I_TMA;
        state_d       = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge I_CLK or posedge I_ASYNC_RESET) begin
    if (I_ASYNC_RESET) begin
      state_q       <= ST_IDLE;
      div_cnt_q     <= 16'h0000;
      div_pend_q    <= 1'b0;
      div_val_q     <= 8'h00;
      tima_pend_q   <= 1'b0;
      tima_val_q    <= 8'h00;
      tima_shadow_q <= 8'h00;
      tima_hold_q   <= 2'd0;
      ovf_cnt_q     <= 2'd0;
      tick_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      div_pend_q    <= div_pend_d;
      div_val_q     <= div_val_d;
      tima_pend_q   <= tima_pend_d;
      tima_val_q    <= tima_val_d;
      tima_shadow_q <= tima_shadow_d;
      tima_hold_q   <= tima_hold_d;
      ovf_cnt_q     <= ovf_cnt_d;
      tick_q        <= tick_d;
    end
  end

  assign O_DIV_DATA   = div_val_q;
  assign O_DIV_WR_EN  = div_wr_en;
  assign O_TIMA_DATA  = tima_val_q;
  assign O_TIMA_WR_EN = tima_wr_en;
  assign O_INT_REQ    = (state_q == ST_RELOAD);

endmodule
